spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
SPI target (mode 0, single-bit MOSI/MISO) that acts as the far end of the CPU's SPI program-memory fetch interface.
- Serves READ (0x03) and WRITE (0x02) commands with a 24-bit address against an internal byte memory.
- Used on-chip as a loadable program/boot store and as the synthesizable responder in system benches.
- A side read port lets local logic read the memory contents directly.

Parameters:
ADDR_W, 5, internal memory address width; DEPTH = 2^ADDR_W bytes.
CMD_READ, 8'h03, read command opcode.
CMD_WRITE, 8'h02, write command opcode.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
spi_cs_n  input  1  chip select, active low, asynchronous to clk.
spi_sclk  input  1  SPI clock from initiator; must be ≤ clk/8.
spi_mosi  input  1  initiator-to-target data.
spi_miso  output  1  target-to-initiator data.
spi_miso_oe  output  1  output enable for spi_miso pad.
busy  output  1  high while a transaction is in progress (synchronized CS active).
wr_strobe  output  1  one-clk pulse on each completed memory byte write.
cmd_err  output  1  one-clk pulse when an unknown opcode is received.
host_addr  input  ADDR_W  side read port address.
host_rdata  output  8  side read data; combinational mem[host_addr].

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Outputs: spi_miso=0, spi_miso_oe=0, busy=0, wr_strobe=0, cmd_err=0.
  - Internal state: FSM=IDLE, bit_cnt=0, byte_cnt=0, addr=0, tx_shift=0.
  - All memory bytes cleared to 0.
- Input synchronization and edge detection:
  - spi_cs_n, spi_sclk and spi_mosi each pass through a 2-flop synchronizer.
  - Rise and fall edges are detected on synced sclk against a third delay flop.
  - mosi is sampled from its synchronized value on the detected rise.
- Bit order and counters:
  - All bytes are MSB first.
  - bit_cnt (3b) increments on every rise while CS is active and wraps 7→0; a wrap marks byte completion.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE.
  - IDLE: when synced CS goes low → CMD, busy=1.
  - CMD: on byte completion:
    - opcode==CMD_READ or CMD_WRITE → ADDR, byte_cnt=0.
    - any other opcode → IGNORE, cmd_err pulses for 1 clk.
  - ADDR: 3 address bytes (bits 23..0).
    - addr takes the low ADDR_W bits; upper bits are ignored.
    - After the 3rd byte → RD_DATA (read) or WR_DATA (write).
  - RD_DATA: spi_miso_oe=1 and spi_miso=tx_shift[7].
    - On each sclk fall with bit_cnt==0: tx_shift<=mem[addr], addr<=addr+1.
    - On other falls: tx_shift<=tx_shift<<1.
    - The first data bit is therefore valid before the first data-phase rise.
  - WR_DATA: on byte completion, mem[addr]<=received byte, addr<=addr+1, wr_strobe pulses for 1 clk.
  - IGNORE: MISO stays tri-stated and MOSI is ignored until CS goes high.
- Address wrap: addr wraps modulo DEPTH in both read and write; streaming is unbounded while CS is low.
- CS deassert (synced CS high) in any state:
  - Next clk: FSM=IDLE, bit_cnt=0, spi_miso_oe=0, busy=0.
  - A partially received byte is discarded with no write.
  - A completed write byte that coincides with the CS-high edge is still committed.
- Latency: pin-to-action latency is 3 clk (2 sync + 1 edge detect). The initiator must hold MOSI stable around sclk rise for at least 3 clk.
- Side read port:
  - host_rdata is combinational from mem[host_addr].
  - A write to the same address is visible on the clk after wr_strobe.
- Reset mid-transaction: rst_n low aborts everything and clears memory. The current CS-low period must then be ignored: after reset the FSM waits for CS high before accepting a new CS-low.

Test Plan:
- Write then read back:
  - Stimulus: CS low, send 02 00 00 04 then A5 3C, CS high. Expect wr_strobe twice, host_addr=4 gives A5, host_addr=5 gives 3C.
  - Stimulus: send 03 00 00 04, clock 16 bits. Expect MISO bytes A5, 3C and spi_miso_oe=1 only during RD_DATA.
- Wrap-around: write 02 00 00 1F then 11 22 (ADDR_W=5) → mem[31]=11, mem[0]=22. Read 03 00 00 1F for 2 bytes → 11, 22.
- Upper address bits ignored: read 03 FF FF E4 → returns mem[4]=A5.
- Bad opcode: send 9F then 16 more bits → cmd_err pulses once, spi_miso_oe stays 0, memory unchanged. The next 03 transaction works normally.
- Aborted byte: send 02 00 00 07 then 5 bits of 0xFF, CS high → no wr_strobe, mem[7]=00, busy=0 within 3 clk.
- Reset mid-read: assert rst_n=0 for 2 clk during a read data phase → spi_miso_oe=0, all host_rdata=00, and no response until CS cycles high then low.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between an initiator (master) and spi_flash_responder (slave).
//
// Signals:
//   spi_cs_n    - chip select, active low, driven by the initiator
//   spi_sclk    - serial clock, mode 0 (idle low, data sampled on rise)
//   spi_mosi    - initiator-to-target data, MSB first
//   spi_miso    - target-to-initiator data, MSB first
//   spi_miso_oe - target pad enable for spi_miso
//
// Framing: a transaction is everything between a falling and a rising edge of
// spi_cs_n. The initiator changes spi_mosi while spi_sclk is low and the target
// samples it on the sclk rise. The target changes spi_miso after an sclk fall
// and the initiator samples it on the following rise. There is no flow
// control: every sclk rise moves exactly one bit in each direction.
`timescale 1ns/1ps
interface spi_flash_responder_if;
    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi,
        input  spi_miso, spi_miso_oe
    );

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi,
        output spi_miso, spi_miso_oe
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash-style responder backed by a small internal byte memory.
// Serves READ and WRITE commands followed by a 24-bit address; the low ADDR_W
// address bits select the byte and the address auto-increments (wrapping) for
// unbounded streaming while CS is low. All SPI pins are oversampled by clk.
//
// Ports:
//   clk, rst_n  - system clock, synchronous active-low reset (clears memory)
//   spi         - SPI pin bundle (slave side)
//   busy        - transaction in progress (synchronized CS active)
//   wr_strobe   - one-clk pulse per committed memory byte write
//   cmd_err     - one-clk pulse when an unknown opcode is received
//   host_addr   - side read port address
//   host_rdata  - combinational mem[host_addr]
//   dbg_state   - current FSM state encoding, for observation only
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_flash_responder_if.slave spi,
    output logic               busy,
    output logic               wr_strobe,
    output logic               cmd_err,
    input  logic [ADDR_W-1:0]  host_addr,
    output logic [7:0]         host_rdata,
    output logic [2:0]         dbg_state
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_IGNORE
    } state_t;

    state_t state, state_next;

    logic cs_s1, cs_s2;
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;
    logic armed;

    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [7:0]        rx_shift;
    logic [7:0]        tx_shift;
    logic [ADDR_W-1:0] addr;
    logic              is_write;
    logic [7:0]        mem [DEPTH];

    logic       sclk_rise, sclk_fall, byte_done;
    logic [7:0] rx_byte;
    logic       do_write, do_err;

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift[6:0], mosi_s2};

    assign busy            = (state != S_IDLE);
    assign spi.spi_miso_oe = (state == S_RD_DATA);
    assign spi.spi_miso    = (state == S_RD_DATA) ? tx_shift[7] : 1'b0;
    assign host_rdata      = mem[host_addr];
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_err     = 1'b0;
        unique case (state)
            S_IDLE: if (armed && !cs_s2) state_next = S_CMD;
            S_CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                        state_next = S_ADDR;
                    end else begin
                        state_next = S_IGNORE;
                        do_err     = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (byte_done && byte_cnt == 2'd2)
                    state_next = is_write ? S_WR_DATA : S_RD_DATA;
            end
            // A byte completing in the same cycle CS rises is still committed.
            S_WR_DATA: do_write = byte_done;
            default: ;
        endcase
        if (state != S_IDLE && cs_s2) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // CS sync resets to "active" so that a CS low still held across
            // reset is never mistaken for a fresh select: armed only sets once
            // a real high level has come through the synchronizer.
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_d    <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            armed     <= 1'b0;
            wr_strobe <= 1'b0;
            cmd_err   <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            rx_shift  <= 8'h00;
            tx_shift  <= 8'h00;
            addr      <= '0;
            is_write  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            cs_s1   <= spi.spi_cs_n;
            cs_s2   <= cs_s1;
            sclk_s1 <= spi.spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= spi.spi_mosi;
            mosi_s2 <= mosi_s1;
            if (cs_s2) armed <= 1'b1;

            wr_strobe <= do_write;
            cmd_err   <= do_err;

            // Bit counting only inside a transaction; CS high drops any
            // partial byte by returning the counter to 0.
            if (state == S_IDLE || cs_s2) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
            end

            unique case (state)
                S_CMD: begin
                    if (byte_done) begin
                        is_write <= (rx_byte == CMD_WRITE);
                        byte_cnt <= 2'd0;
                    end
                end
                S_ADDR: begin
                    // Shifting all 24 bits through leaves exactly the low
                    // ADDR_W address bits behind.
                    if (sclk_rise) begin
                        addr <= {addr[ADDR_W-2:0], mosi_s2};
                        if (byte_done) byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_RD_DATA: begin
                    // Load on the fall that opens each byte so bit 7 is on
                    // MISO before the first rise of that byte.
                    if (sclk_fall) begin
                        if (bit_cnt == 3'd0) begin
                            tx_shift <= mem[addr];
                            addr     <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                S_WR_DATA: begin
                    if (do_write) begin
                        mem[addr] <= rx_byte;
                        addr      <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
module tb_spi_flash_responder;
    localparam int ADDR_W = 5;
    localparam logic [3:0] K_RD  = 4'd1;
    localparam logic [3:0] K_WR  = 4'd2;
    localparam logic [3:0] K_ERR = 4'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_flash_responder_if spi_bus();
    logic              busy, wr_strobe, cmd_err;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_rdata;
    logic [2:0]        dbg_state;

    spi_flash_responder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (spi_bus),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .cmd_err    (cmd_err),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [11:0] exp_q[$];   // {kind, data}
    logic [7:0]  obs_q[$];   // bytes the initiator shifted in from MISO
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [11:0] got);
        logic [11:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind %0d data %h, expected no event", got[11:8], got[7:0]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %h, expected kind %0d data %h",
                         got[11:8], got[7:0], e[11:8], e[7:0]);
            end
        end
    endtask

    // Monitor: every DUT-presented event is matched against the expected queue.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) observe({K_WR, 8'h00});
        if (cmd_err === 1'b1)   observe({K_ERR, 8'h00});
        while (obs_q.size() > 0) observe({K_RD, obs_q.pop_front()});
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift nbits of tx (MSB first); sclk half period is 8 clk.
    task automatic xfer(input logic [7:0] tx, input int nbits, input logic exp_oe,
                        input bit capture, input string name);
        logic [7:0] rx;
        int oe_bad;
        rx = 8'h00;
        oe_bad = 0;
        for (int i = 0; i < nbits; i++) begin
            spi_bus.spi_mosi = tx[7-i];
            tick(8);
            spi_bus.spi_sclk = 1'b1;
            rx = {rx[6:0], spi_bus.spi_miso};
            if (spi_bus.spi_miso_oe !== exp_oe) oe_bad++;
            tick(8);
            spi_bus.spi_sclk = 1'b0;
        end
        check({name, " miso_oe"}, oe_bad, 0);
        if (capture) obs_q.push_back(rx);
    endtask

    task automatic send(input logic [7:0] b);
        xfer(b, 8, 1'b0, 1'b0, "hdr");
    endtask

    task automatic write_byte(input logic [7:0] b);
        exp_q.push_back({K_WR, 8'h00});
        xfer(b, 8, 1'b0, 1'b0, "wdata");
    endtask

    task automatic read_byte(input logic [7:0] exp);
        exp_q.push_back({K_RD, exp});
        xfer(8'h00, 8, 1'b1, 1'b1, "rdata");
    endtask

    task automatic cs_low();
        spi_bus.spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        spi_bus.spi_cs_n = 1'b1;
        tick(6);
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [7:0] a2,
                       input logic [7:0] a1, input logic [7:0] a0);
        send(cmd); send(a2); send(a1); send(a0);
    endtask

    task automatic mem_check(input int a, input logic [7:0] exp);
        host_addr = a[ADDR_W-1:0];
        #1;
        check($sformatf("mem[%0d]", a), host_rdata, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nz;
        spi_bus.spi_cs_n = 1'b1;
        spi_bus.spi_sclk = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        host_addr = '0;

        // Reset state
        tick(3);
        check("reset miso", spi_bus.spi_miso, 0);
        check("reset miso_oe", spi_bus.spi_miso_oe, 0);
        check("reset busy", busy, 0);
        check("reset wr_strobe", wr_strobe, 0);
        check("reset cmd_err", cmd_err, 0);
        mem_check(4, 8'h00);
        rst_n = 1'b1;
        tick(5);

        // Write A5 3C at 4, then check via side port
        cs_low();
        check("busy in txn", busy, 1);
        hdr(8'h02, 8'h00, 8'h00, 8'h04);
        write_byte(8'hA5);
        write_byte(8'h3C);
        cs_high();
        check("busy after txn", busy, 0);
        mem_check(4, 8'hA5);
        mem_check(5, 8'h3C);

        // Read back
        cs_low();
        hdr(8'h03, 8'h00, 8'h00, 8'h04);
        read_byte(8'hA5);
        read_byte(8'h3C);
        cs_high();
        check("miso_oe after read", spi_bus.spi_miso_oe, 0);

        // Address wrap on write and read
        cs_low();
        hdr(8'h02, 8'h00, 8'h00, 8'h1F);
        write_byte(8'h11);
        write_byte(8'h22);
        cs_high();
        mem_check(31, 8'h11);
        mem_check(0, 8'h22);
        cs_low();
        hdr(8'h03, 8'h00, 8'h00, 8'h1F);
        read_byte(8'h11);
        read_byte(8'h22);
        cs_high();

        // Upper address bits ignored
        cs_low();
        hdr(8'h03, 8'hFF, 8'hFF, 8'hE4);
        read_byte(8'hA5);
        cs_high();

        // Unknown opcode: one cmd_err, no MISO drive, memory untouched
        cs_low();
        exp_q.push_back({K_ERR, 8'h00});
        send(8'h9F);
        send(8'h02);
        send(8'hFF);
        cs_high();
        mem_check(4, 8'hA5);
        mem_check(0, 8'h22);
        cs_low();
        hdr(8'h03, 8'h00, 8'h00, 8'h05);
        read_byte(8'h3C);
        cs_high();

        // Aborted write byte: 5 bits then CS high
        cs_low();
        hdr(8'h02, 8'h00, 8'h00, 8'h07);
        xfer(8'hFF, 5, 1'b0, 1'b0, "partial");
        spi_bus.spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("busy 3 clk after cs high", busy, 0);
        tick(4);
        mem_check(7, 8'h00);

        // Reset during read data phase
        cs_low();
        hdr(8'h03, 8'h00, 8'h00, 8'h04);
        xfer(8'h00, 3, 1'b1, 1'b0, "pre-reset");
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("miso_oe after reset", spi_bus.spi_miso_oe, 0);
        check("busy after reset", busy, 0);
        nz = 0;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            host_addr = a[ADDR_W-1:0];
            #1;
            if (host_rdata !== 8'h00) nz++;
        end
        check("memory cleared by reset", nz, 0);
        // Same CS-low period continues: a full read header must be ignored
        hdr(8'h03, 8'h00, 8'h00, 8'h04);
        send(8'h00);
        check("busy while stale cs low", busy, 0);
        cs_high();
        cs_low();
        hdr(8'h03, 8'h00, 8'h00, 8'h04);
        read_byte(8'h00);
        cs_high();

        tick(10);
        check("pending events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
